// File: rtl/depth_event_packer_pkg.sv
// Shared types for the depth event packer: the 225-bit event record, its flag word,
// the packer FSM states and the helper that places a record on the 256-bit stream.
package depth_event_packer_pkg;

  typedef struct packed {
    logic [63:0] ts_ns;
    logic [63:0] update_id;
    logic        side;
    logic [31:0] price_q32;
    logic [31:0] qty_q32;
    logic [31:0] reserved;
  } event_record_t;

  typedef struct packed {
    logic [15:0] idx;
    logic [7:0]  lcnt;
    logic [4:0]  rsvd;
    logic        empty;
    logic        first;
    logic        gap;
  } rec_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEVELS = 2'd1,
    ST_DROP   = 2'd2
  } pk_state_e;

  function automatic logic [255:0] pack_record(
    input logic [63:0] ts_ns,
    input logic [63:0] update_id,
    input logic        side,
    input logic [31:0] price_q32,
    input logic [31:0] qty_q32,
    input rec_flags_t  flags
  );
    event_record_t rec;
    rec.ts_ns     = ts_ns;
    rec.update_id = update_id;
    rec.side      = side;
    rec.price_q32 = price_q32;
    rec.qty_q32   = qty_q32;
    rec.reserved  = flags;
    return {31'b0, rec};
  endfunction

endpackage

// File: rtl/depth_event_packer_if.sv
// Header, level and AXI-Stream output signals of the depth packer; slave = packer side.
interface depth_event_packer_if #(
  parameter int LCW = 5
);
  logic           hdr_valid;
  logic           hdr_ready;
  logic [63:0]    hdr_ts_ns;
  logic [63:0]    hdr_update_id;
  logic [LCW-1:0] hdr_level_count;
  logic           lvl_valid;
  logic           lvl_ready;
  logic           lvl_side;
  logic [31:0]    lvl_price_q32;
  logic [31:0]    lvl_qty_q32;
  logic [255:0]   m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;

  modport slave (
    input  hdr_valid, hdr_ts_ns, hdr_update_id, hdr_level_count,
    input  lvl_valid, lvl_side, lvl_price_q32, lvl_qty_q32, m_axis_tready,
    output hdr_ready, lvl_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output hdr_valid, hdr_ts_ns, hdr_update_id, hdr_level_count,
    output lvl_valid, lvl_side, lvl_price_q32, lvl_qty_q32, m_axis_tready,
    input  hdr_ready, lvl_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/depth_event_packer_fifo.sv
// Synchronous record FIFO (data + last) with registered storage and an occupancy count.
module event_rec_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push, w_do_pop;

  assign w_do_push = i_push && (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
endmodule

// File: rtl/depth_event_packer.sv
// Depth-path packer: one 256-bit record per level, whole-message admission against FIFO space,
// update_id gap detection and status counters.
//   state     | meaning
//   ST_IDLE   | waiting for a header; empty messages are written here directly
//   ST_LEVELS | writing one record per accepted level
//   ST_DROP   | consuming the levels of a discarded message
module depth_event_packer
  import depth_event_packer_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int MAX_LEVELS   = 20,
  parameter bit DROP_ON_FULL = 1'b0,
  parameter bit SEQ_CHECK    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  depth_event_packer_if.slave        bus,
  output logic [31:0]                o_gap_count,
  output logic [31:0]                o_drop_count,
  output logic [31:0]                o_rec_count,
  output logic                       o_err_lvl_clamp
);
  localparam int LCW = $clog2(MAX_LEVELS + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  pk_state_e      r_state, w_next;
  logic [63:0]    r_ts, r_id, r_last_id;
  logic           r_have_last, r_gap, r_err_clamp;
  logic [LCW-1:0] r_n;
  logic [15:0]    r_idx;
  logic [31:0]    r_gap_count, r_drop_count, r_rec_count;

  logic [LCW-1:0] w_clamped, w_need;
  logic [CW-1:0]  w_count, w_free;
  logic           w_clamp_hit, w_space_ok, w_gap, w_hdr_fire, w_drop_hdr, w_lvl_fire, w_last_lvl;
  logic           w_push, w_pop, w_fifo_valid;
  logic [256:0]   w_push_data, w_pop_data;
  rec_flags_t     w_flags;

  assign w_clamp_hit = 32'(bus.hdr_level_count) > 32'(MAX_LEVELS);
  assign w_clamped   = w_clamp_hit ? LCW'(MAX_LEVELS) : bus.hdr_level_count;
  assign w_need      = (w_clamped == '0) ? LCW'(1) : w_clamped;
  // A pop in the current cycle is not credited, keeping admission purely registered.
  assign w_free      = CW'(FIFO_DEPTH) - w_count;
  assign w_space_ok  = 32'(w_need) <= 32'(w_free);
  assign w_gap       = SEQ_CHECK && r_have_last && (bus.hdr_update_id != r_last_id + 64'd1);

  always_comb begin
    w_next        = r_state;
    bus.hdr_ready = 1'b0;
    bus.lvl_ready = 1'b0;
    w_hdr_fire    = 1'b0;
    w_drop_hdr    = 1'b0;
    w_lvl_fire    = 1'b0;
    w_last_lvl    = 1'b0;
    w_push        = 1'b0;
    w_flags       = '0;
    w_push_data   = '0;
    unique case (r_state)
      ST_IDLE: begin
        bus.hdr_ready = !rst && (w_space_ok || DROP_ON_FULL);
        w_hdr_fire    = bus.hdr_valid && bus.hdr_ready;
        if (w_hdr_fire) begin
          if (DROP_ON_FULL && !w_space_ok) begin
            w_drop_hdr = 1'b1;
            w_next     = ST_DROP;
          end else if (w_clamped == '0) begin
            w_push        = 1'b1;
            w_flags.empty = 1'b1;
            w_flags.first = 1'b1;
            w_flags.gap   = w_gap;
            w_push_data   = {1'b1, pack_record(bus.hdr_ts_ns, bus.hdr_update_id, 1'b0,
                                               32'd0, 32'd0, w_flags)};
          end else begin
            w_next = ST_LEVELS;
          end
        end
      end
      ST_LEVELS: begin
        bus.lvl_ready = !rst;
        w_lvl_fire    = bus.lvl_valid && bus.lvl_ready;
        w_last_lvl    = (r_idx == 16'(r_n) - 16'd1);
        w_flags.idx   = r_idx;
        w_flags.lcnt  = 8'(r_n);
        w_flags.first = (r_idx == '0);
        w_flags.gap   = r_gap && (r_idx == '0);
        w_push        = w_lvl_fire;
        w_push_data   = {w_last_lvl, pack_record(r_ts, r_id, bus.lvl_side, bus.lvl_price_q32,
                                                 bus.lvl_qty_q32, w_flags)};
        if (w_lvl_fire && w_last_lvl) w_next = ST_IDLE;
      end
      ST_DROP: begin
        bus.lvl_ready = !rst && (r_n != '0);
        w_lvl_fire    = bus.lvl_valid && bus.lvl_ready;
        w_last_lvl    = (r_n == '0) || (r_idx == 16'(r_n) - 16'd1);
        if ((r_n == '0) || (w_lvl_fire && w_last_lvl)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts         <= '0;
      r_id         <= '0;
      r_last_id    <= '0;
      r_have_last  <= 1'b0;
      r_gap        <= 1'b0;
      r_n          <= '0;
      r_idx        <= '0;
      r_gap_count  <= '0;
      r_drop_count <= '0;
      r_rec_count  <= '0;
      r_err_clamp  <= 1'b0;
    end else begin
      if (w_hdr_fire) begin
        r_ts        <= bus.hdr_ts_ns;
        r_id        <= bus.hdr_update_id;
        r_n         <= w_clamped;
        r_idx       <= '0;
        r_gap       <= w_gap;
        r_last_id   <= bus.hdr_update_id;
        r_have_last <= 1'b1;
        if (w_gap && (r_gap_count != '1))       r_gap_count  <= r_gap_count + 32'd1;
        if (w_drop_hdr && (r_drop_count != '1)) r_drop_count <= r_drop_count + 32'd1;
        if (w_clamp_hit)                        r_err_clamp  <= 1'b1;
      end
      if (w_lvl_fire) r_idx <= r_idx + 16'd1;
      if (w_pop)      r_rec_count <= r_rec_count + 32'd1;
    end
  end

  event_rec_fifo #(
    .WIDTH (257),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_pop_data),
    .o_valid (w_fifo_valid),
    .o_count (w_count)
  );

  assign w_pop             = w_fifo_valid && bus.m_axis_tready;
  assign bus.m_axis_tvalid = w_fifo_valid;
  assign bus.m_axis_tdata  = w_fifo_valid ? w_pop_data[255:0] : '0;
  assign bus.m_axis_tlast  = w_fifo_valid && w_pop_data[256];

  assign o_gap_count     = r_gap_count;
  assign o_drop_count    = r_drop_count;
  assign o_rec_count     = r_rec_count;
  assign o_err_lvl_clamp = r_err_clamp;
endmodule

// File: tb/tb_depth_event_packer.sv
// Bench for depth_event_packer: a stalling instance checked against a queue-based record model
// under directed and random traffic, plus a dropping instance driven through full/clamp cases.
module tb_depth_event_packer;
  localparam int LCW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1;
  logic [31:0] gap0, drop0, rec0, gap1, drop1, rec1;
  logic        err0, err1;

  depth_event_packer_if #(.LCW(LCW)) bus0 ();
  depth_event_packer_if #(.LCW(LCW)) bus1 ();

  depth_event_packer #(.FIFO_DEPTH(16), .MAX_LEVELS(20), .DROP_ON_FULL(1'b0), .SEQ_CHECK(1'b1)) u_dut0 (
    .clk(clk), .rst(rst0), .bus(bus0), .o_gap_count(gap0), .o_drop_count(drop0),
    .o_rec_count(rec0), .o_err_lvl_clamp(err0));

  depth_event_packer #(.FIFO_DEPTH(16), .MAX_LEVELS(20), .DROP_ON_FULL(1'b1), .SEQ_CHECK(1'b1)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .o_gap_count(gap1), .o_drop_count(drop1),
    .o_rec_count(rec1), .o_err_lvl_clamp(err1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [256:0] got, input logic [256:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [256:0] exp_q[$];
  logic [63:0]  m_last_id;
  bit           m_have_last;
  int           m_pops, m_gaps, lvl_gap_max;
  logic [63:0]  cur_ts, cur_id;
  bit           cur_gap;
  int           cur_n;
  bit           rand_rdy = 1'b0;

  function automatic logic [256:0] mk_rec(input logic last, input logic [63:0] ts, input logic [63:0] id,
                                          input logic side, input logic [31:0] p, input logic [31:0] q,
                                          input int idx, input int lcnt, input logic empty, input logic gap);
    logic [15:0] i16;
    logic [7:0]  l8;
    logic        first;
    i16   = idx[15:0];
    l8    = lcnt[7:0];
    first = (idx == 0);
    return {last, 31'b0, ts, id, side, p, q, i16, l8, 5'b0, empty, first, gap};
  endfunction

  always @(negedge clk) begin
    if (!rst0 && bus0.m_axis_tvalid && bus0.m_axis_tready) begin
      if (exp_q.size() == 0) chk("beat_expected", exp_q.size(), 1);
      else begin
        chk("beat", {bus0.m_axis_tlast, bus0.m_axis_tdata}, exp_q.pop_front());
        m_pops++;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus0.m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic start_msg(input logic [63:0] id, input int cnt);
    cur_ts  = {$urandom, $urandom};
    cur_id  = id;
    cur_gap = m_have_last && (id != m_last_id + 64'd1);
    if (cur_gap) m_gaps++;
    m_last_id   = id;
    m_have_last = 1'b1;
    cur_n = (cnt > 20) ? 20 : cnt;
    if (cur_n == 0) exp_q.push_back(mk_rec(1'b1, cur_ts, id, 1'b0, 32'd0, 32'd0, 0, 0, 1'b1, cur_gap));
    @(posedge clk); #1;
    bus0.hdr_valid       = 1'b1;
    bus0.hdr_ts_ns       = cur_ts;
    bus0.hdr_update_id   = id;
    bus0.hdr_level_count = LCW'(cnt);
  endtask

  task automatic finish_hdr();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus0.hdr_ready && t < 300) begin @(negedge clk); t++; end
    chk("hdr_accept", bus0.hdr_ready, 1);
    @(posedge clk); #1;
    bus0.hdr_valid = 1'b0;
  endtask

  task automatic send_levels(input int upto);
    logic        s;
    logic [31:0] p, q;
    int          t, g;
    for (int i = 0; i < upto; i++) begin
      s = 1'($urandom);
      p = $urandom;
      q = $urandom;
      exp_q.push_back(mk_rec(i == cur_n - 1, cur_ts, cur_id, s, p, q, i, cur_n, 1'b0, cur_gap && (i == 0)));
      g = $urandom_range(0, lvl_gap_max);
      if (g > 0) begin repeat (g) @(posedge clk); #1; end
      bus0.lvl_valid = 1'b1; bus0.lvl_side = s; bus0.lvl_price_q32 = p; bus0.lvl_qty_q32 = q;
      t = 0;
      @(negedge clk);
      while (!bus0.lvl_ready && t < 100) begin @(negedge clk); t++; end
      chk("lvl_accept", bus0.lvl_ready, 1);
      @(posedge clk); #1;
      bus0.lvl_valid = 1'b0;
    end
  endtask

  task automatic send_msg(input logic [63:0] id, input int cnt);
    start_msg(id, cnt);
    finish_hdr();
    send_levels(cur_n);
  endtask

  task automatic drain0();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic hdr1(input logic [63:0] id, input int cnt);
    int t;
    @(posedge clk); #1;
    bus1.hdr_valid = 1'b1; bus1.hdr_ts_ns = {$urandom, $urandom};
    bus1.hdr_update_id = id; bus1.hdr_level_count = LCW'(cnt);
    t = 0;
    @(negedge clk);
    while (!bus1.hdr_ready && t < 300) begin @(negedge clk); t++; end
    chk("hdr1_accept", bus1.hdr_ready, 1);
    @(posedge clk); #1;
    bus1.hdr_valid = 1'b0;
  endtask

  task automatic lvl1(input int n, output int taken);
    int t;
    taken = 0;
    for (int i = 0; i < n; i++) begin
      bus1.lvl_valid = 1'b1; bus1.lvl_side = 1'($urandom);
      bus1.lvl_price_q32 = $urandom; bus1.lvl_qty_q32 = $urandom;
      t = 0;
      @(negedge clk);
      while (!bus1.lvl_ready && t < 50) begin @(negedge clk); t++; end
      if (bus1.lvl_ready) taken++;
      @(posedge clk); #1;
      bus1.lvl_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int tk, beats, t, base;
    logic [63:0] id;
    bus0.hdr_valid = 0; bus0.hdr_ts_ns = 0; bus0.hdr_update_id = 0; bus0.hdr_level_count = 0;
    bus0.lvl_valid = 0; bus0.lvl_side = 0; bus0.lvl_price_q32 = 0; bus0.lvl_qty_q32 = 0;
    bus0.m_axis_tready = 0;
    bus1.hdr_valid = 0; bus1.hdr_ts_ns = 0; bus1.hdr_update_id = 0; bus1.hdr_level_count = 0;
    bus1.lvl_valid = 0; bus1.lvl_side = 0; bus1.lvl_price_q32 = 0; bus1.lvl_qty_q32 = 0;
    bus1.m_axis_tready = 0;
    m_have_last = 0; m_last_id = 0; m_pops = 0; m_gaps = 0; lvl_gap_max = 1;
    rst0 = 1; rst1 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", bus0.m_axis_tvalid, 0);
    chk("rst_hdr_ready", bus0.hdr_ready, 0);
    chk("rst_counters", {gap0, drop0, rec0, 31'b0, err0}, 0);
    @(posedge clk); #1;
    rst0 = 0; rst1 = 0;
    @(negedge clk);
    chk("idle_hdr_ready", bus0.hdr_ready, 1);

    // basic three-level message
    bus0.m_axis_tready = 1;
    send_msg(64'd100, 3);
    drain0();
    chk("rec_count_t1", rec0, 3);
    chk("gap_count_t1", gap0, 0);

    // discontinuity then continuity
    send_msg(64'd105, 2);
    drain0();
    chk("gap_count_t2a", gap0, 1);
    send_msg(64'd106, 1);
    drain0();
    chk("gap_count_t2b", gap0, 1);

    // empty message
    base = m_pops;
    start_msg(64'd107, 0);
    finish_hdr();
    @(negedge clk);
    chk("hdr_ready_after_empty", bus0.hdr_ready, 1);
    drain0();
    chk("empty_beats", m_pops - base, 1);
    chk("rec_count_t3", rec0, 7);

    // back-pressure: full FIFO stalls header until four pops
    bus0.m_axis_tready = 0;
    send_msg(64'd108, 16);
    start_msg(64'd109, 4);
    repeat (3) begin @(negedge clk); chk("hdr_stall_full", bus0.hdr_ready, 0); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1; bus0.m_axis_tready = 1;
      @(posedge clk); #1; bus0.m_axis_tready = 0;
      @(negedge clk);
      chk("hdr_ready_after_pops", bus0.hdr_ready, k == 4);
    end
    @(posedge clk); #1;
    bus0.hdr_valid = 0;
    send_levels(4);
    bus0.m_axis_tready = 1;
    drain0();
    chk("rec_count_t4", rec0, 27);

    // reset in the middle of a message
    start_msg(64'd200, 4);
    finish_hdr();
    send_levels(2);
    rst0 = 1;
    @(posedge clk); #1;
    exp_q.delete(); m_have_last = 0; m_pops = 0; m_gaps = 0;
    @(negedge clk);
    chk("midrst_tvalid", bus0.m_axis_tvalid, 0);
    chk("midrst_counters", {gap0, drop0, rec0}, 0);
    @(posedge clk); #1;
    rst0 = 0;
    send_msg(64'd300, 2);
    drain0();
    chk("rec_count_t6", rec0, 2);
    chk("gap_count_t6", gap0, 0);

    // random traffic against the model
    rand_rdy = 1; lvl_gap_max = 2;
    for (int m = 0; m < 40; m++) begin
      id = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : m_last_id + 64'd1;
      send_msg(id, $urandom_range(0, 6));
    end
    rand_rdy = 0;
    @(posedge clk); #1;
    bus0.m_axis_tready = 1;
    drain0();
    chk("rec_count_rand", rec0, m_pops);
    chk("gap_count_rand", gap0, m_gaps);
    chk("err_clamp_dut0", err0, 0);
    chk("drop_count_dut0", drop0, 0);

    // dropping instance: fill, drop on full, clamp, then recover
    hdr1(64'd500, 16);
    lvl1(16, tk);
    chk("dut1_fill_taken", tk, 16);
    @(negedge clk);
    chk("dut1_full_tvalid", bus1.m_axis_tvalid, 1);
    hdr1(64'd501, 5);
    lvl1(5, tk);
    chk("dut1_drop_taken", tk, 5);
    @(negedge clk);
    chk("dut1_drop_count", drop1, 1);
    chk("dut1_no_clamp_yet", err1, 0);
    hdr1(64'd502, 25);
    lvl1(20, tk);
    chk("dut1_clamp_taken", tk, 20);
    @(negedge clk);
    chk("dut1_drop_count2", drop1, 2);
    chk("dut1_err_clamp", err1, 1);
    @(posedge clk); #1;
    bus1.m_axis_tready = 1;
    beats = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus1.m_axis_tvalid && bus1.m_axis_tready) beats++;
    end
    chk("dut1_beats", beats, 16);
    chk("dut1_rec_count", rec1, 16);
    hdr1(64'd503, 1);
    lvl1(1, tk);
    t = 0;
    @(negedge clk);
    while (!bus1.m_axis_tvalid && t < 20) begin @(negedge clk); t++; end
    chk("dut1_recover_flags", {bus1.m_axis_tvalid, bus1.m_axis_tlast, bus1.m_axis_tdata[2:0]}, 5'b11010);
    chk("dut1_gap_count", gap1, 0);
    repeat (3) @(negedge clk);
    chk("dut1_rec_count2", rec1, 17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
